uart_ram_ctrl: RTL
==================

// Module: uart_ram_ctrl
// PURPOSE
//  Buffer controller between uart_receiver/key_filter and the dual-port RAM + uart_sender.
//  Writes each received byte to the next RAM address. A debounced key press replays
//  every stored byte, oldest first, through uart_sender, one byte per tx_done
//  handshake. The buffer then empties for the next capture.
// PARAMETERS
//  AW      8   RAM address width; buffer depth DEPTH = 2**AW bytes
//  RD_LAT  2   RAM read latency in clk cycles, from rdaddress change to valid q (>=1)
// PORTS
//  clk         in   1     system clock (50 MHz)
//  rst_n       in   1     asynchronous active-low reset
//  key_flag    in   1     1-cycle debounced key event pulse from key_filter
//  key_state   in   1     key level at key_flag: 0 = pressed, 1 = released
//  rx_done     in   1     1-cycle pulse: uart_receiver data_byte valid (held until next byte)
//  tx_done     in   1     1-cycle pulse: uart_sender finished current byte
//  wraddress   out  AW    RAM write address
//  wren        out  1     RAM write enable, 1-cycle pulse
//  rdaddress   out  AW    RAM read address
//  send_en     out  1     1-cycle pulse: start uart_sender on RAM q
//  busy        out  1     1 while a replay is in progress
//  byte_count  out  AW+1  bytes currently stored (0..DEPTH)
//  overflow    out  1     sticky: a received byte was dropped
// BEHAVIOUR
//  Reset: wraddress=0, rdaddress=0, wren=0, send_en=0, busy=0, byte_count=0,
//   overflow=0, state=IDLE. Reset mid-replay aborts at once; no further send_en.
//  Capture (state IDLE only):
//   - rx_done at cycle N with byte_count<DEPTH: wren=1 at cycle N+1 with the current
//     wraddress. At N+2: wraddress+1 (wraps mod DEPTH), byte_count+1.
//   - rx_done while byte_count==DEPTH: byte dropped, no wren, overflow<=1.
//   - rx_done while busy: byte dropped, no wren, overflow<=1.
//  Replay trigger: key_flag=1 && key_state=0 in IDLE.
//   - byte_count==0: ignored; stays IDLE.
//   - Otherwise: latch len=byte_count; rdaddress<=0; overflow<=0; busy<=1; go RD_WAIT.
//   - A trigger during busy, or a release event (key_state=1), is ignored.
//   - A trigger in the same cycle as a wren write is taken after that write completes;
//     len then includes that byte.
//  FSM:
//   IDLE      - capture as above; waits for trigger.
//   RD_WAIT   - counts RD_LAT cycles with rdaddress stable, then -> SEND.
//   SEND      - send_en=1 for exactly one cycle -> WAIT_DONE.
//   WAIT_DONE - holds on tx_done. On tx_done:
//               if rdaddress==len-1 -> DONE;
//               else rdaddress+1 -> RD_WAIT.
//   DONE      - 1 cycle: wraddress<=0, rdaddress<=0, byte_count<=0, busy<=0 -> IDLE.
//  Timing:
//   - Key pulse to first send_en: RD_LAT+1 cycles.
//   - tx_done to next send_en: RD_LAT+1 cycles.
//  Rules:
//   - tx_done outside WAIT_DONE is ignored.
//   - send_en never pulses twice without an intervening tx_done.
//   - wren and send_en are never both high in the same cycle.
//   - len==DEPTH replays all addresses 0..DEPTH-1; rdaddress does not wrap during replay.
// TESTING
//  1. Reset, receive 0x11,0x22,0x33, key press -> wren at addr 0,1,2; byte_count=3;
//     three send_en pulses read addr 0,1,2 (tx bytes 11,22,33); busy drops; byte_count=0.
//  2. Key press with byte_count=0 -> no send_en; busy stays 0.
//  3. AW=2: receive 5 bytes -> byte_count=4, overflow=1, wraddress wraps to 0;
//     replay sends 4 bytes; overflow clears at trigger.
//  4. During replay, rx_done and a second key press -> no wren, overflow=1;
//     replay length unchanged.
//  5. Hold tx_done low 1000 cycles in WAIT_DONE -> no extra send_en; rdaddress stable.
//  6. Assert rst_n=0 between send_en #1 and its tx_done -> all outputs reach reset
//     values asynchronously; later tx_done does not restart replay.

Source files
------------

// File: rtl/uart_ram_ctrl.sv
// ---------------------------------------------------------------------------
// uart_ram_ctrl
//
// Buffer controller that sits between uart_receiver/key_filter and a
// dual-port RAM feeding uart_sender. Each received byte is written to the
// next free RAM address. A debounced key press replays every stored byte,
// oldest first, through uart_sender, one byte per tx_done handshake. After
// the replay the buffer is empty again and ready for the next capture.
//
// Parameters
//   AW        RAM address width, buffer depth is 2**AW bytes
//   RD_LAT    RAM read latency in clk cycles (>= 1)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   key_flag    1-cycle debounced key event pulse
//   key_state   key level at key_flag (0 = pressed, 1 = released)
//   rx_done     1-cycle pulse, received byte valid on the RAM data input
//   tx_done     1-cycle pulse, uart_sender finished the current byte
//   wraddress   RAM write address
//   wren        RAM write enable, 1-cycle pulse
//   rdaddress   RAM read address
//   send_en     1-cycle pulse, start uart_sender on RAM q
//   busy        high while a replay is in progress
//   byte_count  number of bytes currently stored (0..2**AW)
//   overflow    sticky flag, a received byte was dropped
// ---------------------------------------------------------------------------
module uart_ram_ctrl #(
    parameter int AW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_flag,
    input  logic          key_state,
    input  logic          rx_done,
    input  logic          tx_done,
    output logic [AW-1:0] wraddress,
    output logic          wren,
    output logic [AW-1:0] rdaddress,
    output logic          send_en,
    output logic          busy,
    output logic [AW:0]   byte_count,
    output logic          overflow
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = $clog2(RD_LAT + 1);

    localparam logic [AW+1:0] DEPTH_W   = (AW + 2)'(DEPTH);
    localparam logic [CW-1:0] LAST_WAIT = CW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        SEND,
        WAIT_DONE,
        DONE
    } state_t;

    state_t        state;
    logic [AW:0]   len;
    logic [CW-1:0] wait_cnt;
    logic          trig_pend;

    logic          trigger;
    logic          rx_accept;
    logic [AW+1:0] pending_count;

    // A write that is still in flight (wren high) already owns a slot, so it
    // is counted when deciding whether another byte fits.
    assign trigger       = key_flag & ~key_state;
    assign pending_count = {1'b0, byte_count} + {{(AW + 1){1'b0}}, wren};
    assign rx_accept     = rx_done && (state == IDLE) && (pending_count < DEPTH_W);

    // Capture and replay FSM. A trigger that coincides with a write (either
    // an accepted rx_done or a wren pulse) is parked in trig_pend and taken
    // once the write has been counted, so the replay length includes it.
    // Any rx_done that is not accepted marks overflow; this is evaluated
    // after the trigger so a byte dropped in the trigger cycle still shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wraddress  <= '0;
            rdaddress  <= '0;
            wren       <= 1'b0;
            send_en    <= 1'b0;
            busy       <= 1'b0;
            byte_count <= '0;
            overflow   <= 1'b0;
            len        <= '0;
            wait_cnt   <= '0;
            trig_pend  <= 1'b0;
        end else begin
            wren    <= 1'b0;
            send_en <= 1'b0;

            case (state)
                IDLE: begin
                    wren <= rx_accept;
                    if (wren) begin
                        wraddress  <= wraddress + 1'b1;
                        byte_count <= byte_count + 1'b1;
                    end
                    if (trigger || trig_pend) begin
                        if (wren || rx_accept) begin
                            trig_pend <= 1'b1;
                        end else begin
                            trig_pend <= 1'b0;
                            if (byte_count != '0) begin
                                len       <= byte_count;
                                rdaddress <= '0;
                                overflow  <= 1'b0;
                                busy      <= 1'b1;
                                wait_cnt  <= '0;
                                state     <= RD_WAIT;
                            end
                        end
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        send_en <= 1'b1;
                        state   <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                SEND: begin
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (tx_done) begin
                        if ({1'b0, rdaddress} == len - 1'b1) begin
                            state <= DONE;
                        end else begin
                            rdaddress <= rdaddress + 1'b1;
                            wait_cnt  <= '0;
                            state     <= RD_WAIT;
                        end
                    end
                end

                DONE: begin
                    wraddress  <= '0;
                    rdaddress  <= '0;
                    byte_count <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (rx_done && !rx_accept) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
